// File: rtl/spi_read_sequencer.sv
// SPI mode-0 READ sequencer: sends CMD_READ plus a 24-bit address, then
// clocks in (req_len+1) bytes and hands them out on a valid/ready stream.
module spi_read_sequencer #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [7:0]  CMD_READ = 8'h03
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_ncs,
  input  logic        spi_miso
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CA_W  = 31;  // command MSB goes straight to mosi at accept
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT_CA,
    S_SHIFT_DATA,
    S_CS_HOLD,
    S_DESELECT
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [CA_W-1:0]  ca_q, ca_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       byte_q, byte_d;
  logic             done_q, done_d;
  logic [6:0]       rx_q, rx_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ncs_q, ncs_d;
  logic             div_end;

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      ca_q        <= '0;
      len_q       <= '0;
      byte_q      <= '0;
      done_q      <= 1'b0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ncs_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      ca_q        <= ca_d;
      len_q       <= len_d;
      byte_q      <= byte_d;
      done_q      <= done_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ncs_q       <= ncs_d;
    end
  end

  // Next-state: half-period timing, shifting, byte assembly and backpressure
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    ca_d        = ca_q;
    len_d       = len_q;
    byte_d      = byte_q;
    done_d      = done_q;
    rx_d        = rx_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q & ~rd_ready;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ncs_d       = ncs_q;
    div_end     = (div_q == DIV_LAST);

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          ncs_d       = 1'b0;
          sclk_d      = 1'b0;
          mosi_d      = CMD_READ[7];
          ca_d        = {CMD_READ[6:0], req_addr};
          len_d       = req_len;
          byte_d      = '0;
          done_d      = 1'b0;
          bit_d       = '0;
          div_d       = '0;
          state_d     = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_SHIFT_CA;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_SHIFT_CA: begin
        if (!div_end) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit while sclk is low
            sclk_d = 1'b0;
            mosi_d = ca_q[CA_W-1];
            ca_d   = {ca_q[CA_W-2:0], 1'b0};
            if (bit_q == 5'd31) begin
              mosi_d  = 1'b0;
              bit_d   = '0;
              state_d = S_SHIFT_DATA;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      S_SHIFT_DATA: begin
        if (!div_end) begin
          div_d = div_q + 8'd1;
        end else if (sclk_q) begin
          div_d  = '0;
          sclk_d = 1'b0;
        end else if (done_q) begin
          // Final low half-period has run out; start the chip-select hold
          div_d   = '0;
          state_d = S_CS_HOLD;
        end else if (bit_q[2:0] == 3'd0 && rd_valid_q) begin
          // Consumer still owns the previous byte: keep sclk low until taken
          div_d = div_q;
        end else begin
          div_d  = '0;
          sclk_d = 1'b1;
          rx_d   = {rx_q[5:0], spi_miso};
          bit_d  = {2'b00, bit_q[2:0] + 3'd1};
          if (bit_q[2:0] == 3'd7) begin
            rd_data_d  = {rx_q, spi_miso};
            rd_valid_d = 1'b1;
            done_d     = (byte_q == len_q);
            byte_d     = byte_q + 8'd1;
          end
        end
      end

      S_CS_HOLD: begin
        if (div_end) begin
          div_d   = '0;
          ncs_d   = 1'b1;
          state_d = S_DESELECT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_DESELECT: begin
        if (div_end) begin
          div_d       = '0;
          busy_d      = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_ncs   = ncs_q;

endmodule

// File: tb/tb_spi_read_sequencer.sv
// Directed bench for spi_read_sequencer: SPI slave model, byte scoreboard,
// one instance at CLK_DIV=2 and one at CLK_DIV=1.
module tb_spi_read_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, rd_valid, rd_ready, busy;
  logic [23:0] req_addr;
  logic [7:0]  req_len, rd_data;
  logic        spi_sclk, spi_mosi, spi_ncs, spi_miso;

  logic        f_req_valid, f_req_ready, f_rd_valid, f_rd_ready, f_busy;
  logic [23:0] f_req_addr;
  logic [7:0]  f_req_len, f_rd_data;
  logic        f_sclk, f_mosi, f_ncs, f_miso;

  int total = 0;
  int bad   = 0;

  spi_read_sequencer #(.CLK_DIV(2), .CMD_READ(8'h03)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ncs(spi_ncs), .spi_miso(spi_miso)
  );

  spi_read_sequencer #(.CLK_DIV(1), .CMD_READ(8'h03)) u_dut_fast (
    .clk(clk), .rst_n(rst_n),
    .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_addr(f_req_addr), .req_len(f_req_len),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_ready(f_rd_ready),
    .busy(f_busy),
    .spi_sclk(f_sclk), .spi_mosi(f_mosi), .spi_ncs(f_ncs), .spi_miso(f_miso)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave model for the CLK_DIV=2 instance: logs mosi, shifts out sl_data
  logic [7:0]  sl_data [256];
  int          rise_cnt = 0;
  logic [31:0] mosi_sr  = '0;
  always @(negedge spi_ncs) rise_cnt = 0;
  always @(posedge spi_sclk) begin
    if (rise_cnt < 32) mosi_sr = {mosi_sr[30:0], spi_mosi};
    rise_cnt++;
  end
  always @(negedge spi_sclk) begin
    int k;
    logic [7:0] b;
    if (rise_cnt >= 32) begin
      k = rise_cnt - 32;
      if (k / 8 < 256) begin
        b = sl_data[k / 8];
        spi_miso = b[7 - (k % 8)];
      end
    end
  end

  // Slave model for the CLK_DIV=1 instance: byte k returns k ^ 0x5A
  int          f_rise = 0;
  logic [31:0] f_mosi_sr = '0;
  always @(negedge f_ncs) f_rise = 0;
  always @(posedge f_sclk) begin
    if (f_rise < 32) f_mosi_sr = {f_mosi_sr[30:0], f_mosi};
    f_rise++;
  end
  always @(negedge f_sclk) begin
    int k;
    logic [7:0] b;
    if (f_rise >= 32) begin
      k = f_rise - 32;
      b = 8'(k / 8) ^ 8'h5A;
      f_miso = b[7 - (k % 8)];
    end
  end

  // Scoreboards and ncs-low / rd_valid pulse monitors
  logic [7:0] exp_q[$];
  logic [7:0] f_exp_q[$];
  int ncs_cycles = 0, f_ncs_cycles = 0, rd_pulses = 0, f_bytes = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (!spi_ncs) ncs_cycles++;
    if (!f_ncs) f_ncs_cycles++;
    if (rd_valid && !prev_v) rd_pulses++;
    prev_v = rd_valid;
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) chk("rd_extra_byte", 64'(exp_q.size()), 64'd1);
      else chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
    end
    if (f_rd_valid && f_rd_ready) begin
      f_bytes++;
      if (f_exp_q.size() == 0) chk("f_rd_extra_byte", 64'(f_exp_q.size()), 64'd1);
      else chk("f_rd_data", 64'(f_rd_data), 64'(f_exp_q.pop_front()));
    end
  end

  task automatic do_req(input logic [23:0] a, input logic [7:0] l);
    int n = 0;
    @(posedge clk); #1;
    req_addr = a; req_len = l; req_valid = 1'b1; ncs_cycles = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 2000);
    if (!req_ready) chk("req_accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_ncs_high(input int bound);
    int n = 0;
    do begin @(negedge clk); n++; end while (!spi_ncs && n < bound);
    if (!spi_ncs) chk("ncs_high_timeout", 64'(spi_ncs), 64'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < bound);
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int stall_err;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rd_ready = 1'b1;
    f_req_valid = 1'b0; f_req_addr = '0; f_req_len = '0; f_rd_ready = 1'b1;
    spi_miso = 1'b0; f_miso = 1'b0;
    for (int i = 0; i < 256; i++) sl_data[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sclk", 64'(spi_sclk), 64'd0);
    chk("rst_ncs", 64'(spi_ncs), 64'd1);
    chk("rst_mosi", 64'(spi_mosi), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("req_ready_after_reset", 64'(req_ready), 64'd1);

    // Single byte read, check framing and deselect timing
    sl_data[0] = 8'hA5; exp_q.push_back(8'hA5); rd_pulses = 0;
    do_req(24'h123456, 8'd0);
    wait_ncs_high(1000);
    chk("t1_busy_deselect0", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_busy_deselect1", 64'(busy), 64'd1);
    chk("t1_req_ready_deselect1", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("t1_busy_idle", 64'(busy), 64'd0);
    chk("t1_req_ready_idle", 64'(req_ready), 64'd1);
    chk("t1_ncs_low_cycles", 64'(ncs_cycles), 64'd164);
    chk("t1_rise_edges", 64'(rise_cnt), 64'd40);
    chk("t1_mosi_cmd_addr", 64'(mosi_sr), 64'h03123456);
    chk("t1_rd_pulses", 64'(rd_pulses), 64'd1);
    chk("t1_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Four bytes, rd_ready held high: no sclk stall anywhere
    for (int i = 0; i < 4; i++) begin
      sl_data[i] = 8'(i);
      exp_q.push_back(8'(i));
    end
    do_req(24'hABCDEF, 8'd3);
    wait_ncs_high(2000);
    chk("t2_ncs_low_cycles", 64'(ncs_cycles), 64'd260);
    chk("t2_rise_edges", 64'(rise_cnt), 64'd64);
    chk("t2_mosi_cmd_addr", 64'(mosi_sr), 64'h03ABCDEF);
    wait_idle(100);
    chk("t2_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: first byte held for 60 cycles
    rd_ready = 1'b0;
    sl_data[0] = 8'h5A; sl_data[1] = 8'hC3;
    exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    do_req(24'h00F0F0, 8'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 2000);
    if (!rd_valid) chk("t3_rd_valid_timeout", 64'(rd_valid), 64'd1);
    repeat (3) @(negedge clk);
    stall_err = 0;
    for (int i = 0; i < 57; i++) begin
      @(negedge clk);
      if (spi_sclk !== 1'b0 || spi_ncs !== 1'b0) stall_err++;
    end
    chk("t3_stall_sclk_ncs_low", 64'(stall_err), 64'd0);
    chk("t3_stall_no_edges", 64'(rise_cnt), 64'd40);
    chk("t3_stall_rd_data_held", 64'(rd_data), 64'h5A);
    chk("t3_stall_rd_valid_held", 64'(rd_valid), 64'd1);
    @(posedge clk); #1 rd_ready = 1'b1;
    wait_ncs_high(2000);
    chk("t3_rise_edges", 64'(rise_cnt), 64'd48);
    wait_idle(100);
    chk("t3_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Reset during the address phase, then a fresh request
    do_req(24'h654321, 8'd0);
    n = 0;
    while (rise_cnt < 12 && n < 2000) begin @(negedge clk); n++; end
    if (rise_cnt < 12) chk("t4_addr_phase_timeout", 64'(rise_cnt), 64'd12);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t4_ncs", 64'(spi_ncs), 64'd1);
    chk("t4_sclk", 64'(spi_sclk), 64'd0);
    chk("t4_rd_valid", 64'(rd_valid), 64'd0);
    chk("t4_rd_data", 64'(rd_data), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    sl_data[0] = 8'h3C; exp_q.push_back(8'h3C);
    do_req(24'h0FF00F, 8'd0);
    wait_ncs_high(1000);
    chk("t4_mosi_cmd_addr", 64'(mosi_sr), 64'h030FF00F);
    chk("t4_rise_edges", 64'(rise_cnt), 64'd40);
    wait_idle(100);
    chk("t4_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Second request held during a transaction is taken only after IDLE
    sl_data[0] = 8'h99; exp_q.push_back(8'h99);
    do_req(24'h111111, 8'd0);
    req_valid = 1'b1; req_addr = 24'h222222; req_len = 8'd0;
    repeat (20) @(negedge clk);
    chk("t5_req_ready_busy", 64'(req_ready), 64'd0);
    wait_ncs_high(1000);
    chk("t5_first_mosi", 64'(mosi_sr), 64'h03111111);
    sl_data[0] = 8'h77; exp_q.push_back(8'h77);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 100);
    if (!req_ready) chk("t5_accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_ncs_high(1000);
    chk("t5_second_mosi", 64'(mosi_sr), 64'h03222222);
    chk("t5_rise_edges", 64'(rise_cnt), 64'd40);
    wait_idle(100);
    chk("t5_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // CLK_DIV=1, 256 bytes
    for (int i = 0; i < 256; i++) f_exp_q.push_back(8'(i) ^ 8'h5A);
    @(posedge clk); #1;
    f_req_addr = 24'hFFFFF0; f_req_len = 8'd255; f_req_valid = 1'b1;
    f_ncs_cycles = 0; f_bytes = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_req_ready && n < 100);
    if (!f_req_ready) chk("t6_accept_timeout", 64'(f_req_ready), 64'd1);
    @(posedge clk); #1 f_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_ncs && n < 10000);
    if (!f_ncs) chk("t6_ncs_high_timeout", 64'(f_ncs), 64'd1);
    chk("t6_rise_edges", 64'(f_rise), 64'd2080);
    chk("t6_ncs_low_cycles", 64'(f_ncs_cycles), 64'd4162);
    chk("t6_mosi_cmd_addr", 64'(f_mosi_sr), 64'h03FFFFF0);
    repeat (4) @(negedge clk);
    chk("t6_byte_count", 64'(f_bytes), 64'd256);
    chk("t6_scoreboard_empty", 64'(f_exp_q.size()), 64'd0);
    chk("t6_idle", 64'(f_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
